// File: rtl/fifo_upsizer.sv
// Read-side upsizer: pops DATA_WIDTH words from a fall-through FIFO and packs
// RATIO of them LSB-lane-first into one registered valid/ready output word.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_FILL  | popping FIFO words into lanes, emitting full words
// S_FLUSH | no pops; emit the partial word once the output register is free
module fifo_upsizer #(
  parameter int DATA_WIDTH = 8,
  parameter int RATIO      = 4
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_empty,
  output logic                          o_rd_en,
  input  logic [DATA_WIDTH-1:0]         i_data,
  input  logic                          i_flush,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [DATA_WIDTH*RATIO-1:0]   o_data,
  output logic [RATIO-1:0]              o_keep,
  output logic                          o_flushing
);

  localparam int CW = $clog2(RATIO);
  localparam int LW = DATA_WIDTH * (RATIO - 1);
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  typedef enum logic {S_FILL, S_FLUSH} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [LW-1:0]   lanes_q;
  logic [LW-1:0]   flush_lanes;
  logic [RATIO-1:0] flush_keep;
  logic            out_free;
  logic            complete;
  logic            flush_emit;

  assign out_free   = !o_valid || i_ready;
  assign complete   = o_rd_en && (cnt_q == LAST);
  assign flush_emit = (state_q == S_FLUSH) && (cnt_q != '0) && out_free;

  always_ff @(posedge i_clock) begin
    if (i_reset) state_q <= S_FILL;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FILL:  if (i_flush) state_d = S_FLUSH;
      S_FLUSH: if ((cnt_q == '0) || out_free) state_d = S_FILL;
      default: state_d = S_FILL;
    endcase
  end

  // Only the completing beat needs a free output register; partial beats
  // keep filling lanes behind a stalled word.
  always_comb begin
    o_rd_en    = 1'b0;
    o_flushing = 1'b0;
    case (state_q)
      S_FILL:  o_rd_en = !i_reset && !i_empty && ((cnt_q != LAST) || out_free);
      S_FLUSH: o_flushing = 1'b1;
      default: o_rd_en = 1'b0;
    endcase
  end

  always_comb begin
    flush_lanes = '0;
    flush_keep  = '0;
    for (int k = 0; k < RATIO - 1; k++) begin
      if (k < int'(cnt_q)) begin
        flush_lanes[k*DATA_WIDTH +: DATA_WIDTH] = lanes_q[k*DATA_WIDTH +: DATA_WIDTH];
        flush_keep[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_keep  <= '0;
      cnt_q   <= '0;
      lanes_q <= '0;
    end else if (complete) begin
      o_data  <= {i_data, lanes_q};
      o_keep  <= '1;
      o_valid <= 1'b1;
      cnt_q   <= '0;
      lanes_q <= '0;
    end else if (flush_emit) begin
      o_data  <= {DATA_WIDTH'(0), flush_lanes};
      o_keep  <= flush_keep;
      o_valid <= 1'b1;
      cnt_q   <= '0;
      lanes_q <= '0;
    end else begin
      if (o_rd_en) begin
        for (int k = 0; k < RATIO - 1; k++) begin
          if (int'(cnt_q) == k) lanes_q[k*DATA_WIDTH +: DATA_WIDTH] <= i_data;
        end
        cnt_q <= cnt_q + CW'(1);
      end
      if (o_valid && i_ready) o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_upsizer.sv
// Bench for fifo_upsizer: a RATIO=4 and a RATIO=3 instance, each fed by a
// zero-latency fall-through FIFO model, with output words scoreboarded.
module tb_fifo_upsizer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4, empty4, rd4, flush4, valid4, ready4, fl4;
  logic [7:0]  data4;
  logic [31:0] odata4;
  logic [3:0]  keep4;

  logic        rst3, empty3, rd3, flush3, valid3, ready3, fl3;
  logic [7:0]  data3;
  logic [23:0] odata3;
  logic [2:0]  keep3;

  fifo_upsizer #(.DATA_WIDTH(8), .RATIO(4)) dut4 (
    .i_clock(clk), .i_reset(rst4), .i_empty(empty4), .o_rd_en(rd4),
    .i_data(data4), .i_flush(flush4), .o_valid(valid4), .i_ready(ready4),
    .o_data(odata4), .o_keep(keep4), .o_flushing(fl4)
  );

  fifo_upsizer #(.DATA_WIDTH(8), .RATIO(3)) dut3 (
    .i_clock(clk), .i_reset(rst3), .i_empty(empty3), .o_rd_en(rd3),
    .i_data(data3), .i_flush(flush3), .o_valid(valid3), .i_ready(ready3),
    .o_data(odata3), .o_keep(keep3), .o_flushing(fl3)
  );

  logic [7:0]  fifo4[$];
  logic [7:0]  fifo3[$];
  logic [63:0] sb4[$];
  logic [63:0] sb3[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fifo_drive();
    empty4 = (fifo4.size() == 0);
    data4  = empty4 ? 8'h00 : fifo4[0];
    empty3 = (fifo3.size() == 0);
    data3  = empty3 ? 8'h00 : fifo3[0];
  endtask

  task automatic push4(input logic [7:0] b);
    fifo4.push_back(b);
    fifo_drive();
  endtask

  task automatic push3(input logic [7:0] b);
    fifo3.push_back(b);
    fifo_drive();
  endtask

  // One clock: sample pops/handshakes before the edge, apply them after it.
  task automatic tick();
    logic p4, p3, h4, h3;
    logic [63:0] w4, w3;
    @(negedge clk);
    p4 = rd4;
    p3 = rd3;
    h4 = valid4 && ready4;
    h3 = valid3 && ready3;
    w4 = 64'({keep4, odata4});
    w3 = 64'({keep3, odata3});
    @(posedge clk);
    #1;
    if (p4 && fifo4.size() > 0) void'(fifo4.pop_front());
    if (p3 && fifo3.size() > 0) void'(fifo3.pop_front());
    fifo_drive();
    if (h4) begin
      if (sb4.size() == 0) check("sb4_underflow", 64'(sb4.size()), 64'd1);
      else                 check("word4", w4, sb4.pop_front());
    end
    if (h3) begin
      if (sb3.size() == 0) check("sb3_underflow", 64'(sb3.size()), 64'd1);
      else                 check("word3", w3, sb3.pop_front());
    end
    #1;
  endtask

  task automatic drain4(input int max_cycles);
    int n = 0;
    while (sb4.size() > 0 && n < max_cycles) begin
      tick();
      n++;
    end
    check("drain4", 64'(sb4.size()), 64'd0);
  endtask

  initial begin
    logic [31:0] w;
    int nv, first, last;
    rst4 = 1'b1; rst3 = 1'b1;
    flush4 = 1'b0; flush3 = 1'b0;
    ready4 = 1'b0; ready3 = 1'b0;
    fifo_drive();
    push4(8'hEE);
    push3(8'hEE);

    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_rd_en", 64'(rd4), 64'd0);
      check("rst_valid", 64'(valid4), 64'd0);
      check("rst_data", 64'(odata4), 64'd0);
      check("rst_keep", 64'(keep4), 64'd0);
      check("rst_rd_en3", 64'(rd3), 64'd0);
    end
    check("rst_no_pop", 64'(fifo4.size()), 64'd1);
    rst4 = 1'b0; rst3 = 1'b0;
    fifo4.delete();
    fifo3.delete();
    fifo_drive();

    // basic packing
    ready4 = 1'b1;
    push4(8'h11); push4(8'h22); push4(8'h33); push4(8'h44);
    sb4.push_back(64'({4'hF, 32'h44332211}));
    repeat (4) tick();
    check("basic_popped", 64'(fifo4.size()), 64'd0);
    check("basic_valid", 64'(valid4), 64'd1);
    check("basic_data", 64'(odata4), 64'h44332211);
    check("basic_keep", 64'(keep4), 64'hF);
    tick();
    check("basic_valid_drop", 64'(valid4), 64'd0);

    // back-pressure
    ready4 = 1'b0;
    for (int i = 1; i <= 8; i++) push4(8'(i));
    sb4.push_back(64'({4'hF, 32'h04030201}));
    sb4.push_back(64'({4'hF, 32'h08070605}));
    repeat (10) tick();
    check("bp_fifo_left", 64'(fifo4.size()), 64'd1);
    check("bp_rd_en_low", 64'(rd4), 64'd0);
    check("bp_data_held", 64'(odata4), 64'h04030201);
    check("bp_valid_held", 64'(valid4), 64'd1);
    ready4 = 1'b1;
    drain4(20);
    check("bp_fifo_empty", 64'(fifo4.size()), 64'd0);
    check("bp_valid_drop", 64'(valid4), 64'd0);

    // back-to-back
    w = '0;
    for (int i = 0; i < 12; i++) begin
      push4(8'(8'h30 + i));
      w[(i % 4)*8 +: 8] = 8'(8'h30 + i);
      if (i % 4 == 3) sb4.push_back(64'({4'hF, w}));
    end
    nv = 0; first = -1; last = -1;
    for (int t = 1; t <= 14; t++) begin
      tick();
      if (valid4) begin
        nv++;
        if (first < 0) first = t;
        last = t;
      end
    end
    check("b2b_count", 64'(nv), 64'd3);
    check("b2b_first", 64'(first), 64'd4);
    check("b2b_last", 64'(last), 64'd12);
    check("b2b_sb_empty", 64'(sb4.size()), 64'd0);

    // partial flush
    push4(8'hAA); push4(8'hBB);
    sb4.push_back(64'({4'b0011, 32'h0000BBAA}));
    repeat (2) tick();
    flush4 = 1'b1;
    tick();
    flush4 = 1'b0;
    check("fl_flushing", 64'(fl4), 64'd1);
    check("fl_valid_wait", 64'(valid4), 64'd0);
    tick();
    check("fl_flushing_done", 64'(fl4), 64'd0);
    check("fl_valid", 64'(valid4), 64'd1);
    check("fl_data", 64'(odata4), 64'h0000BBAA);
    check("fl_keep", 64'(keep4), 64'h3);
    tick();
    check("fl_valid_drop", 64'(valid4), 64'd0);

    // flush with nothing buffered
    flush4 = 1'b1;
    tick();
    flush4 = 1'b0;
    check("fl0_flushing", 64'(fl4), 64'd1);
    tick();
    check("fl0_flushing_done", 64'(fl4), 64'd0);
    check("fl0_no_word", 64'(valid4), 64'd0);

    // flush coinciding with the completing beat
    push4(8'hC1); push4(8'hC2); push4(8'hC3); push4(8'hC4);
    sb4.push_back(64'({4'hF, 32'hC4C3C2C1}));
    repeat (3) tick();
    flush4 = 1'b1;
    tick();
    flush4 = 1'b0;
    check("flc_flushing", 64'(fl4), 64'd1);
    check("flc_valid", 64'(valid4), 64'd1);
    check("flc_keep", 64'(keep4), 64'hF);
    tick();
    check("flc_flushing_done", 64'(fl4), 64'd0);
    check("flc_no_extra", 64'(valid4), 64'd0);
    check("sb4_final", 64'(sb4.size()), 64'd0);

    // RATIO=3: flush stalled behind a held word
    push3(8'h01); push3(8'h02); push3(8'h03);
    sb3.push_back(64'({3'b111, 24'h030201}));
    repeat (3) tick();
    check("r3_valid", 64'(valid3), 64'd1);
    push3(8'h5A);
    tick();
    check("r3_partial_pop", 64'(fifo3.size()), 64'd0);
    flush3 = 1'b1;
    tick();
    flush3 = 1'b0;
    check("r3_flushing", 64'(fl3), 64'd1);
    push3(8'h77);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("r3_stall_flushing", 64'(fl3), 64'd1);
      check("r3_stall_rd_en", 64'(rd3), 64'd0);
    end
    check("r3_held_data", 64'(odata3), 64'h030201);
    sb3.push_back(64'({3'b001, 24'h00005A}));
    ready3 = 1'b1;
    tick();
    check("r3_fl_done", 64'(fl3), 64'd0);
    check("r3_fl_valid", 64'(valid3), 64'd1);
    check("r3_fl_data", 64'(odata3), 64'h00005A);
    check("r3_fl_keep", 64'(keep3), 64'h1);
    tick();
    check("r3_pop77", 64'(fifo3.size()), 64'd0);
    check("r3_valid_drop", 64'(valid3), 64'd0);

    // reset in the middle of a flush
    flush3 = 1'b1;
    tick();
    flush3 = 1'b0;
    check("r3_fl2_flushing", 64'(fl3), 64'd1);
    rst3 = 1'b1;
    tick();
    rst3 = 1'b0;
    check("r3_rst_valid", 64'(valid3), 64'd0);
    check("r3_rst_flushing", 64'(fl3), 64'd0);
    check("r3_rst_keep", 64'(keep3), 64'd0);
    tick();
    check("r3_rst_no_emit", 64'(valid3), 64'd0);
    check("sb3_final", 64'(sb3.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
